// File: rtl/hazard_forward_unit_if.sv
// ID-stage request and pipeline-control signals of the hazard/forwarding unit.
// master drives the ID-stage request; slave is the hazard_forward_unit side.
interface hazard_forward_unit_if #(
    parameter int NUM_RD_PORTS = 3,
    parameter int REG_ADDR_W   = 4,
    parameter int CNT_W        = 16
);
    logic                               id_valid;
    logic                               id_rf_e;
    logic                               id_load;
    logic [REG_ADDR_W-1:0]              id_rd;
    logic [NUM_RD_PORTS*REG_ADDR_W-1:0] id_src_addr;
    logic [NUM_RD_PORTS-1:0]            id_src_use;
    logic                               branch_taken;
    logic [NUM_RD_PORTS*2-1:0]          fwd_sel;
    logic                               pc_le;
    logic                               ifid_le;
    logic                               nop_sel;
    logic                               ifid_flush;
    logic [CNT_W-1:0]                   stall_cnt;
    logic [CNT_W-1:0]                   flush_cnt;

    modport master (
        output id_valid, id_rf_e, id_load, id_rd, id_src_addr, id_src_use, branch_taken,
        input  fwd_sel, pc_le, ifid_le, nop_sel, ifid_flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rf_e, id_load, id_rd, id_src_addr, id_src_use, branch_taken,
        output fwd_sel, pc_le, ifid_le, nop_sel, ifid_flush, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the 5-stage pipeline.
// Define HAZ_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_forward_unit #(
    parameter int NUM_RD_PORTS = 3,
    parameter int REG_ADDR_W   = 4,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_forward_unit_if.slave hif
);
    typedef struct packed {
        logic                  v;
        logic                  rf_e;
        logic                  load;
        logic [REG_ADDR_W-1:0] rd;
    } stage_t;

    localparam logic [REG_ADDR_W-1:0] PC_ADDR = '1;

    stage_t ex_q;
    stage_t mem_q;
    stage_t wb_q;

    logic [NUM_RD_PORTS*2-1:0] fwd_raw;
    logic                      hazard_raw;
    logic                      stall;
    logic                      flush;

    function automatic logic writes(input stage_t s, input logic [REG_ADDR_W-1:0] a);
        return s.v && s.rf_e && (s.rd == a);
    endfunction

    // The PC address is never forwarded, so it can neither select a stage nor raise a load-use stall.
    always_comb begin
        logic [REG_ADDR_W-1:0] src;
        src        = '0;
        fwd_raw    = '0;
        hazard_raw = 1'b0;
        for (int k = 0; k < NUM_RD_PORTS; k++) begin
            src = hif.id_src_addr[k*REG_ADDR_W +: REG_ADDR_W];
            if (hif.id_src_use[k] && (src != PC_ADDR)) begin
                if (writes(ex_q, src)) begin
                    fwd_raw[2*k +: 2] = 2'b01;
                end else if (writes(mem_q, src)) begin
                    fwd_raw[2*k +: 2] = 2'b10;
                end else if (writes(wb_q, src)) begin
                    fwd_raw[2*k +: 2] = 2'b11;
                end
                if (writes(ex_q, src) && ex_q.load) begin
                    hazard_raw = 1'b1;
                end
            end
        end
    end

    assign stall = reset && hazard_raw;
    assign flush = reset && !hazard_raw && hif.branch_taken;

    always_comb begin
        hif.fwd_sel    = '0;
        hif.pc_le      = 1'b1;
        hif.ifid_le    = 1'b1;
        hif.nop_sel    = 1'b0;
        hif.ifid_flush = flush;
        if (reset) begin
            hif.fwd_sel = fwd_raw;
        end
        if (stall) begin
            hif.pc_le   = 1'b0;
            hif.ifid_le = 1'b0;
            hif.nop_sel = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (stall || !hif.id_valid) begin
                ex_q <= '0;
            end else begin
                ex_q <= '{v: 1'b1, rf_e: hif.id_rf_e, load: hif.id_load, rd: hif.id_rd};
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_ONE;
            end
            if (flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_ONE;
            end
        end
    end

    assign hif.stall_cnt = reset ? stall_q : '0;
    assign hif.flush_cnt = reset ? flush_q : '0;
`else
    assign hif.stall_cnt = '0;
    assign hif.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed and randomized bench for hazard_forward_unit against an instruction-history model.
module tb_hazard_forward_unit;
    localparam int NP = 3;
    localparam int AW = 4;
    localparam int CW = 16;
    localparam int PC_REG = (1 << AW) - 1;

    logic clk = 1'b0;
    logic reset;

    hazard_forward_unit_if #(.NUM_RD_PORTS(NP), .REG_ADDR_W(AW), .CNT_W(CW)) hif();

    hazard_forward_unit #(.NUM_RD_PORTS(NP), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .hif  (hif)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        bit w;
        bit ld;
        int rd;
    } ent_t;

    // hist[0] is the most recently issued instruction (age 1 = EX, 2 = MEM, 3 = WB)
    ent_t hist[3];
    int   n_stall = 0;
    int   n_flush = 0;
    int   tests   = 0;
    int   fails   = 0;

    bit d_valid, d_rfe, d_load, d_br;
    int d_rd;
    int d_src[NP];
    bit d_use[NP];

    logic [2*NP-1:0] e_fwd;
    bit              e_hz, e_pc, e_ifid, e_nop, e_flush;
    int              e_scnt, e_fcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input bit v, input bit w, input bit ld, input int rd,
                          input int s0, input int s1, input int s2, input bit [2:0] use_, input bit br);
        d_valid = v; d_rfe = w; d_load = ld; d_rd = rd; d_br = br;
        d_src[0] = s0; d_src[1] = s1; d_src[2] = s2;
        for (int k = 0; k < NP; k++) d_use[k] = use_[k];
    endtask

    task automatic apply();
        hif.id_valid     = d_valid;
        hif.id_rf_e      = d_rfe;
        hif.id_load      = d_load;
        hif.id_rd        = d_rd[AW-1:0];
        hif.branch_taken = d_br;
        for (int k = 0; k < NP; k++) begin
            hif.id_src_addr[k*AW +: AW] = d_src[k][AW-1:0];
            hif.id_src_use[k]           = d_use[k];
        end
    endtask

    task automatic model_eval();
        e_fwd = '0; e_hz = 0; e_pc = 1; e_ifid = 1; e_nop = 0; e_flush = 0;
        e_scnt = 0; e_fcnt = 0;
        if (reset) begin
            for (int k = 0; k < NP; k++) begin
                if (d_use[k] && d_src[k] != PC_REG) begin
                    int sel = 0;
                    for (int age = 1; age <= 3; age++) begin
                        if (hist[age-1].v && hist[age-1].w && hist[age-1].rd == d_src[k]) begin
                            sel = age;
                            break;
                        end
                    end
                    e_fwd[2*k +: 2] = sel[1:0];
                    if (hist[0].v && hist[0].w && hist[0].ld && hist[0].rd == d_src[k]) e_hz = 1;
                end
            end
            if (e_hz) begin
                e_pc = 0; e_ifid = 0; e_nop = 1;
            end else begin
                e_flush = d_br;
            end
`ifdef HAZ_PERF_CNT_EN
            e_scnt = n_stall;
            e_fcnt = n_flush;
`endif
        end
    endtask

    task automatic model_clock();
        if (!reset) begin
            for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
            n_stall = 0;
            n_flush = 0;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            if (d_valid && !e_hz) hist[0] = '{1, d_rfe, d_load, d_rd};
            else                  hist[0] = '{0, 0, 0, 0};
            if (e_hz && n_stall < (1 << CW) - 1)    n_stall++;
            if (e_flush && n_flush < (1 << CW) - 1) n_flush++;
        end
    endtask

    task automatic begin_cyc(input string tag);
        apply();
        @(negedge clk);
        model_eval();
        chk({tag, ".fwd_sel"},    32'(hif.fwd_sel),    32'(e_fwd));
        chk({tag, ".pc_le"},      32'(hif.pc_le),      32'(e_pc));
        chk({tag, ".ifid_le"},    32'(hif.ifid_le),    32'(e_ifid));
        chk({tag, ".nop_sel"},    32'(hif.nop_sel),    32'(e_nop));
        chk({tag, ".ifid_flush"}, 32'(hif.ifid_flush), 32'(e_flush));
        chk({tag, ".stall_cnt"},  32'(hif.stall_cnt),  32'(e_scnt));
        chk({tag, ".flush_cnt"},  32'(hif.flush_cnt),  32'(e_fcnt));
    endtask

    task automatic end_cyc();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    function automatic int rnd_reg();
        return ($urandom_range(0, 9) == 0) ? PC_REG : int'($urandom_range(0, 4));
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};

        // reset with a valid writer of r1 in ID
        reset = 1'b0;
        set_id(1, 1, 0, 1, 1, 1, 1, 3'b111, 0);
        for (int i = 0; i < 2; i++) begin
            begin_cyc("reset");
            chk("reset_pc_le", 32'(hif.pc_le), 32'd1);
            chk("reset_fwd", 32'(hif.fwd_sel), 32'd0);
            end_cyc();
        end

        reset = 1'b1;
        set_id(1, 1, 0, 1, 1, 0, 0, 3'b001, 0);
        begin_cyc("post_reset");
        chk("post_reset_fwd", 32'(hif.fwd_sel), 32'd0);
        end_cyc();

        set_id(1, 1, 0, 5, 1, 0, 0, 3'b001, 0);
        begin_cyc("fwd_ex");
        chk("fwd_ex_const", 32'(hif.fwd_sel[1:0]), 32'd1);
        end_cyc();

        set_id(1, 0, 0, 9, 1, 0, 0, 3'b001, 0);
        begin_cyc("fwd_mem");
        chk("fwd_mem_const", 32'(hif.fwd_sel[1:0]), 32'd2);
        end_cyc();
        begin_cyc("fwd_wb");
        chk("fwd_wb_const", 32'(hif.fwd_sel[1:0]), 32'd3);
        end_cyc();
        begin_cyc("fwd_rf");
        chk("fwd_rf_const", 32'(hif.fwd_sel[1:0]), 32'd0);
        end_cyc();

        set_id(1, 1, 0, 3, 0, 0, 0, 3'b000, 0);
        begin_cyc("r3_a");
        end_cyc();
        begin_cyc("r3_b");
        end_cyc();
        set_id(1, 0, 0, 0, 3, 3, 3, 3'b101, 0);
        begin_cyc("ex_prio");
        chk("ex_prio_const", 32'(hif.fwd_sel), 32'b010001);
        end_cyc();

        set_id(1, 1, 1, 2, 0, 0, 0, 3'b000, 0);
        begin_cyc("ldr_r2");
        end_cyc();
        set_id(1, 1, 0, 4, 0, 2, 0, 3'b010, 0);
        begin_cyc("load_use");
        chk("load_use_pc_le", 32'(hif.pc_le), 32'd0);
        chk("load_use_nop", 32'(hif.nop_sel), 32'd1);
        end_cyc();
        begin_cyc("after_stall");
        chk("after_stall_fwd", 32'(hif.fwd_sel[3:2]), 32'd2);
        chk("after_stall_pc_le", 32'(hif.pc_le), 32'd1);
`ifdef HAZ_PERF_CNT_EN
        chk("after_stall_cnt", 32'(hif.stall_cnt), 32'd1);
`endif
        end_cyc();

        set_id(1, 1, 0, 14, 0, 0, 0, 3'b000, 1);
        begin_cyc("branch");
        chk("branch_flush", 32'(hif.ifid_flush), 32'd1);
        end_cyc();
        set_id(1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        begin_cyc("branch_done");
        end_cyc();

        set_id(1, 1, 1, 6, 0, 0, 0, 3'b000, 0);
        begin_cyc("ldr_r6");
        end_cyc();
        set_id(1, 1, 0, 14, 6, 0, 0, 3'b001, 1);
        begin_cyc("br_hazard");
        chk("br_hazard_flush", 32'(hif.ifid_flush), 32'd0);
        chk("br_hazard_nop", 32'(hif.nop_sel), 32'd1);
        end_cyc();
        begin_cyc("br_retry");
        chk("br_retry_flush", 32'(hif.ifid_flush), 32'd1);
        end_cyc();

        set_id(1, 1, 0, 15, 0, 0, 0, 3'b000, 0);
        begin_cyc("wr_pc");
        end_cyc();
        set_id(1, 0, 0, 0, 15, 0, 0, 3'b001, 0);
        begin_cyc("rd_pc");
        chk("rd_pc_fwd", 32'(hif.fwd_sel), 32'd0);
        end_cyc();

        set_id(1, 1, 1, 7, 0, 0, 0, 3'b000, 0);
        begin_cyc("ldr_r7");
        end_cyc();
        set_id(1, 1, 0, 8, 7, 7, 7, 3'b111, 0);
        begin_cyc("stall_r7");
        end_cyc();
        reset = 1'b0;
        begin_cyc("rst_stall");
        chk("rst_stall_nop", 32'(hif.nop_sel), 32'd0);
        end_cyc();
        reset = 1'b1;
        begin_cyc("rst_after");
        chk("rst_after_pc_le", 32'(hif.pc_le), 32'd1);
        chk("rst_after_nop", 32'(hif.nop_sel), 32'd0);
        chk("rst_after_cnt", 32'(hif.stall_cnt), 32'd0);
        end_cyc();

        for (int n = 0; n < 400; n++) begin
            bit ld;
            reset = ($urandom_range(0, 39) != 0);
            ld    = ($urandom_range(0, 2) == 0);
            set_id($urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0, ld,
                   ld ? int'($urandom_range(0, 4)) : rnd_reg(),
                   rnd_reg(), rnd_reg(), rnd_reg(), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 4) == 0);
            begin_cyc("rnd");
            end_cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
